// File: rtl/pipe_rca_pkg.sv
// Shared definitions for the pipelined ripple-carry adder: the chunk-width
// derivation and the per-stage pipeline record.
package pipe_rca_pkg;

    // Upper bound on WIDTH; stage records carry operand bits at this width.
    localparam int MAX_WIDTH = 64;

    function automatic int chunk_width(input int width, input int stages);
        return width / stages;
    endfunction

    // sum_lo holds finished result bits in place. a_hi/b_hi hold the operand
    // bits not yet consumed, shifted down so the next chunk is always at bit 0.
    typedef struct packed {
        logic                 valid;
        logic [MAX_WIDTH-1:0] sum_lo;
        logic [MAX_WIDTH-1:0] a_hi;
        logic [MAX_WIDTH-1:0] b_hi;
        logic                 carry;
        logic                 a_msb;
        logic                 b_msb;
    } stage_rec_t;

endpackage

// File: rtl/pipe_rca_adder_if.sv
// Operand/result handshake bundle for pipe_rca_adder.
interface pipe_rca_adder_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/rca_chunk.sv
// Combinational CW-bit ripple-carry adder built from single-bit full adders.
module fulladder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module rca_chunk #(
    parameter int CW = 4
) (
    input  logic [CW-1:0] a,
    input  logic [CW-1:0] b,
    input  logic          cin,
    output logic [CW-1:0] s,
    output logic          cout
);
    logic [CW:0] c;

    assign c[0] = cin;

    for (genvar gi = 0; gi < CW; gi++) begin : g_bit
        fulladder u_fa (
            .a    (a[gi]),
            .b    (b[gi]),
            .cin  (c[gi]),
            .s    (s[gi]),
            .cout (c[gi+1])
        );
    end

    assign cout = c[CW];
endmodule

// File: rtl/pipe_rca_adder.sv
// Pipelined ripple-carry adder/subtractor: STAGES registered CW-bit chunks with
// a collapsing valid/ready enable chain, one operation per clock.
module pipe_rca_adder
    import pipe_rca_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    pipe_rca_adder_if.slave bus
);
    localparam int CW = chunk_width(WIDTH, STAGES);

    if (WIDTH < 1 || WIDTH > MAX_WIDTH || STAGES < 1 || STAGES > WIDTH ||
        (WIDTH % STAGES) != 0) begin : g_bad_params
        $error("pipe_rca_adder: illegal WIDTH/STAGES combination");
    end

    logic [WIDTH-1:0]        b_eff;
    stage_rec_t              head_rec;
    stage_rec_t [STAGES:0]   link;
    logic [STAGES-1:0]       vld;
    logic [STAGES-1:0]       en;
    logic                    ovf_next;
    logic                    ovf_reg;

    // Subtraction is a + ~b + 1; cin is ignored in that mode.
    always_comb begin
        b_eff          = bus.sub ? ~bus.b : bus.b;
        head_rec       = '0;
        head_rec.valid = bus.in_valid;
        head_rec.a_hi  = MAX_WIDTH'(bus.a);
        head_rec.b_hi  = MAX_WIDTH'(b_eff);
        head_rec.carry = bus.sub | bus.cin;
        head_rec.a_msb = bus.a[WIDTH-1];
        head_rec.b_msb = b_eff[WIDTH-1];
    end

    assign link[0] = head_rec;

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        stage_rec_t    up_rec;
        stage_rec_t    st_next;
        stage_rec_t    st_reg;
        logic [CW-1:0] chunk_s;
        logic          chunk_co;

        assign up_rec = link[gi];

        rca_chunk #(.CW(CW)) u_chunk (
            .a    (up_rec.a_hi[CW-1:0]),
            .b    (up_rec.b_hi[CW-1:0]),
            .cin  (up_rec.carry),
            .s    (chunk_s),
            .cout (chunk_co)
        );

        always_comb begin
            st_next                     = up_rec;
            st_next.sum_lo[gi*CW +: CW] = chunk_s;
            st_next.a_hi                = up_rec.a_hi >> CW;
            st_next.b_hi                = up_rec.b_hi >> CW;
            st_next.carry               = chunk_co;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                st_reg <= '0;
            end else if (en[gi]) begin
                st_reg <= st_next;
            end
        end

        // A stage may load if it, or any stage below it, is empty.
        assign vld[gi]     = st_reg.valid;
        assign en[gi]      = ~(&vld[STAGES-1:gi]) | bus.out_ready;
        assign link[gi+1]  = st_reg;

        if (gi == STAGES - 1) begin : g_last
            assign ovf_next = (up_rec.a_msb == up_rec.b_msb) &&
                              (st_next.sum_lo[WIDTH-1] != up_rec.a_msb);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_reg <= 1'b0;
        end else if (en[STAGES-1]) begin
            ovf_reg <= ovf_next;
        end
    end

    assign bus.in_ready  = en[0];
    assign bus.out_valid = link[STAGES].valid;
    assign bus.sum       = link[STAGES].sum_lo[WIDTH-1:0];
    assign bus.cout      = link[STAGES].carry;
    assign bus.ovf       = ovf_reg;

endmodule

// File: tb/tb_pipe_rca_adder.sv
// Bench for pipe_rca_adder: directed literals, backpressure, random streaming
// against an arithmetic reference scoreboard, and reset mid-flight.
module tb_pipe_rca_adder;
    localparam int W = 8;
    localparam int S = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    pipe_rca_adder_if #(.WIDTH(W)) ifc ();
    pipe_rca_adder_if #(.WIDTH(1)) ifc1 ();

    pipe_rca_adder #(.WIDTH(W), .STAGES(S)) dut (.clk(clk), .rst_n(rst_n), .bus(ifc));
    pipe_rca_adder #(.WIDTH(1), .STAGES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(ifc1));

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        int           acc;
    } exp_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } dir_t;

    int   n_vec  = 0;
    int   n_bad  = 0;
    int   cyc    = 0;
    logic chk_en = 1'b0;
    exp_t q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain unsigned/signed integer arithmetic.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input logic sub);
        exp_t e;
        int ua, ub, sa, sb, us, ss;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        us = sub ? ua - ub : ua + ub + int'(cin);
        ss = sub ? sa - sb : sa + sb + int'(cin);
        e.sum  = W'(us);
        e.cout = sub ? (ua >= ub) : (us >= (1 << W));
        e.ovf  = (ss > (1 << (W-1)) - 1) || (ss < -(1 << (W-1)));
        e.acc  = 0;
        return e;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge rst_n) q.delete();

    // Scoreboard compare: occupancy sets in_ready, head age sets out_valid.
    always @(negedge clk) begin : p_cmp
        exp_t e;
        logic ev;
        if (rst_n && chk_en) begin
            check("in_ready", ifc.in_ready, (q.size() < S) || ifc.out_ready);
            ev = (q.size() > 0) && ((cyc - q[0].acc) >= S - 1);
            check("out_valid", ifc.out_valid, ev);
            if (ifc.out_valid && q.size() > 0) begin
                check("sum", ifc.sum, q[0].sum);
                check("cout", ifc.cout, q[0].cout);
                check("ovf", ifc.ovf, q[0].ovf);
                if (ifc.out_ready) void'(q.pop_front());
            end
            if (ifc.in_valid && ifc.in_ready) begin
                e     = model(ifc.a, ifc.b, ifc.cin, ifc.sub);
                e.acc = cyc + 1;
                q.push_back(e);
            end
        end
    end

    task automatic run_dir(input dir_t d);
        exp_t e;
        int   lat;
        e = model(d.a, d.b, d.cin, d.sub);
        check("model_sum", e.sum, d.sum);
        check("model_cout", e.cout, d.cout);
        check("model_ovf", e.ovf, d.ovf);
        ifc.a = d.a; ifc.b = d.b; ifc.cin = d.cin; ifc.sub = d.sub;
        ifc.in_valid = 1'b1;
        @(negedge clk);
        check("dir_accept", ifc.in_ready, 1);
        @(posedge clk); #1;
        ifc.in_valid = 1'b0;
        lat = 0;
        while (!ifc.out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("dir_latency", lat, S - 1);
        check("dir_sum", ifc.sum, d.sum);
        check("dir_cout", ifc.cout, d.cout);
        check("dir_ovf", ifc.ovf, d.ovf);
        $display("dir a=%02h b=%02h cin=%0d sub=%0d -> sum=%02h cout=%0d ovf=%0d",
                 d.a, d.b, d.cin, d.sub, ifc.sum, ifc.cout, ifc.ovf);
        @(posedge clk); #1;
    endtask

    dir_t         dirs [4];
    logic [W-1:0] bp_a [4];
    logic [W-1:0] bp_b [4];
    int           idx;
    int           acc_cnt;

    initial begin
        dirs[0] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        dirs[1] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
        dirs[2] = '{8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0};
        dirs[3] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
        bp_a = '{8'h10, 8'hF0, 8'h7F, 8'h33};
        bp_b = '{8'h22, 8'h20, 8'h7F, 8'hCC};

        ifc.in_valid = 0; ifc.a = 0; ifc.b = 0; ifc.cin = 0; ifc.sub = 0; ifc.out_ready = 1;
        ifc1.in_valid = 0; ifc1.a = 0; ifc1.b = 0; ifc1.cin = 0; ifc1.sub = 0; ifc1.out_ready = 1;

        #1 rst_n = 1'b0;
        #1;
        check("rst_out_valid", ifc.out_valid, 0);
        check("rst_sum", ifc.sum, 0);
        check("rst_cout", ifc.cout, 0);
        check("rst_ovf", ifc.ovf, 0);
        check("rst_in_ready", ifc.in_ready, 1);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_in_ready", ifc.in_ready, 1);
        chk_en = 1'b1;

        // WIDTH=1, STAGES=1: full-adder truth table, result one edge after accept.
        for (int i = 0; i < 8; i++) begin
            ifc1.a = i[2]; ifc1.b = i[1]; ifc1.cin = i[0]; ifc1.in_valid = 1'b1;
            @(negedge clk);
            check("fa_in_ready", ifc1.in_ready, 1);
            @(posedge clk); #1;
            ifc1.in_valid = 1'b0;
            check("fa_valid", ifc1.out_valid, 1);
            check("fa_sum", ifc1.sum, i[2] ^ i[1] ^ i[0]);
            check("fa_cout", ifc1.cout, $countones(i[2:0]) >= 2);
            $display("fa a=%0d b=%0d cin=%0d -> sum=%0d cout=%0d", i[2], i[1], i[0], ifc1.sum, ifc1.cout);
        end
        @(posedge clk); #1;
        check("fa_idle", ifc1.out_valid, 0);

        for (int k = 0; k < 4; k++) run_dir(dirs[k]);

        // Backpressure: 4 ops offered with out_ready low, released after 6 cycles.
        idx = 0;
        for (int c = 0; c < 60 && !(idx == 4 && q.size() == 0); c++) begin
            ifc.out_ready = (c >= 6);
            ifc.in_valid  = (idx < 4);
            ifc.a = bp_a[idx & 3]; ifc.b = bp_b[idx & 3]; ifc.cin = idx[0]; ifc.sub = 1'b0;
            @(negedge clk);
            if (c == 5) begin
                check("bp_accepts", idx, 2);
                check("bp_in_ready_low", ifc.in_ready, 0);
            end
            if (ifc.in_valid && ifc.in_ready) idx++;
            @(posedge clk); #1;
        end
        check("bp_drained", (idx == 4) && (q.size() == 0), 1);
        $display("backpressure: %0d ops accepted", idx);
        ifc.in_valid = 1'b0; ifc.out_ready = 1'b1;

        // Random streaming with random in_valid/out_ready.
        acc_cnt = 0;
        for (int c = 0; c < 3000 && !(acc_cnt >= 100 && q.size() == 0); c++) begin
            ifc.in_valid  = (acc_cnt < 100) && ($urandom_range(3) != 0);
            ifc.a         = W'($urandom);
            ifc.b         = W'($urandom);
            ifc.cin       = 1'($urandom);
            ifc.sub       = 1'($urandom);
            ifc.out_ready = ($urandom_range(2) != 0);
            @(negedge clk);
            if (ifc.in_valid && ifc.in_ready) acc_cnt++;
            @(posedge clk); #1;
        end
        check("rnd_done", (acc_cnt == 100) && (q.size() == 0), 1);
        $display("random: %0d ops streamed", acc_cnt);
        ifc.in_valid = 1'b0; ifc.out_ready = 1'b1;

        // Reset mid-flight: two ops in the pipe are discarded.
        ifc.out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            ifc.a = bp_a[k]; ifc.b = bp_b[k]; ifc.cin = 1'b0; ifc.sub = 1'b0;
            ifc.in_valid = 1'b1;
            @(posedge clk); #1;
        end
        ifc.in_valid = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", ifc.out_valid, 0);
        check("midrst_sum", ifc.sum, 0);
        check("midrst_in_ready", ifc.in_ready, 1);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        check("midrst_post_valid", ifc.out_valid, 0);
        ifc.out_ready = 1'b1;
        run_dir(dirs[0]);
        repeat (4) @(posedge clk);
        #1;
        check("final_empty", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/pipe_rca_adder.md
# pipe_rca_adder

Parametrised, pipelined ripple-carry adder/subtractor built from full-adder slices, with a valid/ready handshake on both sides. It generalises the single-bit full adder to a WIDTH-bit datapath. The carry chain is split into STAGES registered chunks so that throughput is one operation per clock. It is the arithmetic building block for the tutorial datapaths that need multi-bit add/sub at a clock rate the full ripple chain cannot meet.

## Interface
Parameters:
- WIDTH, 8, operand/result width in bits; WIDTH ≥ 1
- STAGES, 2, number of pipeline register stages; 1 ≤ STAGES ≤ WIDTH, WIDTH % STAGES == 0 (elaboration error otherwise); chunk width CW = WIDTH/STAGES

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operand transaction present
- in_ready  out  1  block can accept this cycle (combinational)
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry in (ignored when sub=1)
- sub  in  1  0: a+b+cin; 1: a−b (a + ~b + 1)
- out_valid  out  1  result present
- out_ready  in  1  downstream accepts result
- sum  out  WIDTH  result bits
- cout  out  1  carry out of MSB (sub: 1 = no borrow)
- ovf  out  1  signed two's-complement overflow

## Operation
- Input transfer when in_valid && in_ready; output transfer when out_valid && out_ready.
- Stage k (0..STAGES−1) adds bits [k·CW +: CW] of a and b' (b' = sub ? ~b : b) with carry c_k; c_0 = sub ? 1 : cin. Stage k registers the cumulative lower sum bits, the upper unconsumed a/b' bits, the carry out, a valid bit and the MSB operand bits needed for ovf.
- Final stage register drives sum, cout, ovf, out_valid directly (no output logic).
- ovf = (a[W−1] == b'[W−1]) && (sum[W−1] != a[W−1]).
- Arithmetic is modulo 2^WIDTH; cout is the true carry out of bit WIDTH−1.
- Per-stage load enable: en_k = !valid_k || rdy_k, with rdy_{STAGES−1} = out_ready and rdy_k = en_{k+1}. in_ready = en_0. Bubbles collapse: an empty stage always loads.
- When a stage loads but its upstream is not transferring, its valid clears to 0 (data registers may hold).
- Transactions emerge in acceptance order; none are dropped or duplicated.
- Capacity: STAGES transactions in flight.

## Timing
- Reset (rst_n low, asynchronous): all valid bits 0, so out_valid = 0. sum = 0, cout = 0, ovf = 0, and all stage data registers 0. in_ready = 1 while in reset and after release.
- Latency: an operand accepted at rising edge t produces out_valid = 1 with its result right after edge t + STAGES − 1. For STAGES=1, the result appears right after the accepting edge.
- Throughput: 1 transaction/cycle while out_ready = 1.
- in_ready depends combinationally on out_ready and the stage valids. It never depends on in_valid (no combinational loop upstream).
- Full pipe with out_ready = 0: in_ready = 0, and outputs hold stable until transfer.
- Simultaneous in and out transfer with the pipe full: both occur in the same cycle, and occupancy is unchanged.
- Reset asserted mid-operation: all in-flight transactions are discarded immediately. The first post-reset output is the first post-reset input.

## Structure
- Package pipe_rca_pkg holds the CW derivation function and the stage-record typedef, parametrised via a function or localparam (fields: valid, sum_lo, a_hi, b_hi, carry, a_msb, b_msb).
- Sub-module rca_chunk: a CW-bit combinational ripple adder made from fulladder instances, with ports a, b, cin, s, cout. It is instantiated once per stage with a generate loop.
- Top level contains only the stage registers, the enable chain and the operand inversion.

## Test plan
- WIDTH=1, STAGES=1: cycle sub=0 through all 8 combinations of a, b, cin → sum/cout match the full-adder truth table (e.g. 1,1,1 → sum 1, cout 1). Result appears 1 edge after accept.
- Defaults: a=8'hFF, b=8'h01, cin=0 → after 2 edges sum=8'h00, cout=1, ovf=0. Also a=8'h7F, b=8'h01 → sum=8'h80, cout=0, ovf=1.
- Subtract: sub=1, a=8'h05, b=8'h07, cin=1 (ignored) → sum=8'hFE, cout=0, ovf=0. Also a=8'h80, b=8'h01 → sum=8'h7F, cout=1, ovf=1.
- Backpressure: hold out_ready=0 and offer 4 back-to-back ops → in_ready drops after 2 accepts. Release out_ready → 4 results in order, each correct, with no gaps once streaming.
- Streaming: 100 random ops with in_valid and out_ready randomly toggled, checked against a reference-model scoreboard → zero mismatches and zero lost or extra results.
- Reset mid-flight: accept 2 ops, assert rst_n low between edges → out_valid=0 and sum=0 immediately. After release, only new ops appear at the output.
